qam16_nibble_packer: RTL
========================

QAM16_NIBBLE_PACKER -- requirements
Module: qam16_nibble_packer

Interface
REQ-001 Parameter FRAME_BYTES, default 48: bytes per frame; tlast marks the last byte; legal range 1..65535.
REQ-002 Parameter FIFO_DEPTH, default 8: output buffer entries; power of two, at least 4.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 din  input  4  demapped QAM16 symbol (Gray-coded nibble).
REQ-006 wren  input  1  din valid strobe, one nibble per high cycle, no backpressure.
REQ-007 clr  input  1  synchronous flush.
REQ-008 m_axis_tdata  output  8  packed byte.
REQ-009 m_axis_tvalid  output  1  head byte valid.
REQ-010 m_axis_tready  input  1  consumer accepts.
REQ-011 m_axis_tlast  output  1  head byte is last of frame.
REQ-012 overflow  output  1  sticky, set when a byte is dropped.
REQ-013 level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 Packer FSM states: EMPTY (no nibble held) and HALF (high nibble held); reset state is EMPTY.
REQ-015 EMPTY with wren: latch din as the high nibble; go to HALF.
REQ-016 HALF with wren: form byte {held, din}, issue push, go to EMPTY; first nibble in time is always bits 7:4.
REQ-017 No wren: state and held nibble unchanged.
REQ-018 Byte counter 0..FRAME_BYTES-1 advances on every push attempt, including dropped ones, and wraps to 0.
REQ-019 Stored tlast = 1 when the counter equals FRAME_BYTES-1 at push; FRAME_BYTES=1 sets tlast on every byte.
REQ-020 FIFO is first-word-fall-through.
  - m_axis_tvalid = (level != 0).
  - tdata and tlast come from the head entry.
REQ-021 Pop occurs when tvalid and tready are both high.
  - tdata and tlast hold stable while tvalid is high and tready is low.
REQ-022 Latency: a byte pushed on edge N is visible on m_axis_* immediately after edge N when the FIFO was empty.
REQ-023 Push and pop in the same cycle: level unchanged; legal at any level, including full.
REQ-024 Push with FIFO full and no pop in the same cycle:
  - the byte is discarded;
  - overflow goes to 1 on the next edge;
  - FIFO contents are unchanged.
REQ-025 Pop when empty cannot occur (tvalid is 0); tready is ignored while tvalid is low.
REQ-026 clr high on an edge, with priority over wren and pop in that cycle:
  - FSM goes to EMPTY; held nibble is discarded;
  - FIFO is emptied; counter is zeroed;
  - overflow is cleared.
REQ-027 overflow stays 1 until clr or reset.

Reset
REQ-028 While rst_n is low:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, overflow=0, level=0;
  - FSM=EMPTY, counter=0, FIFO pointers=0.
REQ-029 Reset asserted mid-frame or mid-byte discards all buffered data; the first wren after release is treated as a high nibble.

Structure
REQ-030 Shared package qam16_rx_pkg holds:
  - NIBBLE_W=4, BYTE_W=8;
  - the FRAME_BYTES default;
  - the FSM state enumeration.
REQ-031 Buffer lives in one sub-module rx_byte_fifo: 9 bits wide (tlast plus byte), FIFO_DEPTH entries, synchronous flush input, level output.
REQ-032 Packer FSM and frame counter live in the top module.

Verification
REQ-033 Packing and latency (tready=1): wren nibbles 0xA, 0x5 on consecutive cycles -> tdata=0xA5 valid one edge after the 0x5 edge; level returns to 0.
REQ-034 Frame boundary: FRAME_BYTES=4, 16 nibbles 0x0..0xF -> bytes 0x01, 0x23, 0x45, 0x67 with tlast on 0x67, then 0x89..0xEF with tlast on 0xEF.
REQ-035 Backpressure and overflow (FIFO_DEPTH=8, tready=0):
  - 18 nibbles -> level=8, overflow=1, bytes 1..8 retained;
  - with tready=1 afterwards, bytes 1..8 drain in order; byte 9 is absent.
REQ-036 Simultaneous push and pop at full: level stays 8; output order is intact; overflow stays 0.
REQ-037 Flush with a held nibble:
  - send nibble 0x3, pulse clr, then send 0xC, 0xD -> only byte 0xCD is emitted;
  - counter restarts, so tlast position is counted from 0xCD.
REQ-038 Reset mid-stream: assert rst_n=0 with 3 bytes buffered and one nibble held -> tvalid=0 and level=0 immediately; after release, 0x1, 0x2 yields 0x12.

Source files
------------

// File: rtl/qam16_rx_pkg.sv
// -----------------------------------------------------------------------------
// qam16_rx_pkg
// Shared definitions for the QAM16 receive-side nibble packer:
//   NIBBLE_W / BYTE_W       symbol and byte widths
//   FRAME_BYTES_DEFAULT     default number of bytes per frame
//   pack_state_e            packer FSM state encoding
// -----------------------------------------------------------------------------
package qam16_rx_pkg;

    localparam int NIBBLE_W            = 4;
    localparam int BYTE_W              = 8;
    localparam int FRAME_BYTES_DEFAULT = 48;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } pack_state_e;

endpackage

// File: rtl/rx_byte_fifo.sv
// -----------------------------------------------------------------------------
// rx_byte_fifo
// First-word-fall-through buffer for packed bytes plus their tlast flag.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   flush        synchronous empty; overrides push and pop in the same cycle
//   push/wr_data write request and {tlast, byte} entry
//   pop          read request; ignored while empty
//   rd_data      head entry, forced to zero while empty
//   level        current occupancy (0..DEPTH)
//   empty        no entries held
//   drop         push refused this cycle (full with no simultaneous pop)
// -----------------------------------------------------------------------------
module rx_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == LW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // At full, a simultaneous pop frees the head slot, which is exactly where
    // wr_ptr points, so the write can proceed.
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !flush && full && !pop_ok;

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    assign level   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + LW'(1);
                2'b01:   count_d = count_q - LW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/qam16_nibble_packer.sv
// -----------------------------------------------------------------------------
// qam16_nibble_packer
// Packs demapped QAM16 nibbles into bytes (first nibble -> bits 7:4), tags the
// last byte of each FRAME_BYTES frame and buffers them for an AXI-Stream sink.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   din, wren        nibble and its valid strobe (no backpressure)
//   clr              synchronous flush of packer, frame counter, buffer, overflow
//   m_axis_*         byte stream out (tdata, tvalid, tready, tlast)
//   overflow         sticky: a byte was dropped because the buffer was full
//   level            buffer occupancy
//
// state    | meaning
// ---------+------------------------------------------
// ST_EMPTY | no nibble held; next wren is a high nibble
// ST_HALF  | high nibble held; next wren completes a byte
// -----------------------------------------------------------------------------
module qam16_nibble_packer
    import qam16_rx_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NIBBLE_W-1:0]           din,
    input  logic                          wren,
    input  logic                          clr,
    output logic [BYTE_W-1:0]             m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int                CNT_W    = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_BYTES - 1);

    pack_state_e          state_q, state_d;
    logic [NIBBLE_W-1:0]  held_q, held_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 overflow_q, overflow_d;

    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_drop;
    logic [BYTE_W:0]      fifo_wr_data;
    logic [BYTE_W:0]      fifo_rd_data;

    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q | fifo_drop;
        push       = 1'b0;
        if (clr) begin
            state_d    = ST_EMPTY;
            held_d     = '0;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end else if (wren) begin
            case (state_q)
                ST_EMPTY: begin
                    held_d  = din;
                    state_d = ST_HALF;
                end
                ST_HALF: begin
                    push    = 1'b1;
                    state_d = ST_EMPTY;
                    // Counts every completed byte, dropped or not, so frame
                    // alignment survives an overflow.
                    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            held_q     <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign fifo_wr_data = {(cnt_q == CNT_LAST), held_q, din};
    assign pop          = m_axis_tvalid && m_axis_tready;

    rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (clr),
        .push    (push),
        .wr_data (fifo_wr_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .level   (level),
        .empty   (fifo_empty),
        .drop    (fifo_drop)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_rd_data[BYTE_W-1:0];
    assign m_axis_tlast  = fifo_rd_data[BYTE_W];
    assign overflow      = overflow_q;

endmodule
